// File: rtl/ic_pkg.sv
// Shared definitions for the address router: FSM state encoding, the default
// three-region memory map, and the outstanding-counter width helper.
package ic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,  // nothing outstanding
    ST_ROUTE = 2'd1,  // one or more requests outstanding to cur_tgt
    ST_ERR   = 2'd2   // decode-error response pending
  } router_state_t;

  localparam int DEF_NREG = 3;

  // Region i lives in slice [32i+31:32i].
  localparam logic [DEF_NREG*32-1:0] DEF_MAP_MATCH =
    {32'h4000_0000, 32'h2000_0000, 32'h1000_0000};
  localparam logic [DEF_NREG*32-1:0] DEF_MAP_MASK =
    {32'hF000_0000, 32'hFFFF_0000, 32'hFFFF_C000};

  // Bits needed to hold an outstanding count in 0..max_out.
  function automatic int out_cnt_width(input int max_out);
    return $clog2(max_out + 1);
  endfunction

endpackage

// File: rtl/ic_region_match.sv
// Combinational priority address decoder: one-hot select of the lowest
// matching region, plus a flag when no region matches.
module ic_region_match
  import ic_pkg::*;
#(
  parameter int                     NREG      = DEF_NREG,
  parameter logic [NREG*32-1:0]     MAP_MATCH = DEF_MAP_MATCH,
  parameter logic [NREG*32-1:0]     MAP_MASK  = DEF_MAP_MASK
) (
  input  logic [31:0]     addr,
  output logic [NREG-1:0] sel,
  output logic            no_match
);

  logic [NREG-1:0] hit;

  // Compare the address against every region in parallel.
  // NOTE: every variable written in always_comb gets a default first so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    hit = '0;
    for (int i = 0; i < NREG; i++) begin
      hit[i] = ((addr & MAP_MASK[32*i +: 32]) == MAP_MATCH[32*i +: 32]);
    end
  end

  // Isolating the lowest set bit gives lowest-index priority.
  assign sel      = hit & (~hit + NREG'(1));
  assign no_match = ~|hit;

endmodule

// File: rtl/ic_addr_router.sv
// Address router: decodes each request to one of NREG targets, forwards it
// while tracking outstanding requests to the current target, and answers
// unmapped addresses with a one-entry decode-error response.
// Optional feature: define IC_ADDR_ROUTER_ERRLOG_EN to keep a saturating
// decode-error counter and the last failing address; otherwise both outputs
// are tied to zero.
module ic_addr_router
  import ic_pkg::*;
#(
  parameter int                 NREG      = DEF_NREG,
  parameter int                 MAX_OUT   = 4,
  parameter logic [NREG*32-1:0] MAP_MATCH = DEF_MAP_MATCH,
  parameter logic [NREG*32-1:0] MAP_MASK  = DEF_MAP_MASK
) (
  input  logic            g_clk,
  input  logic            g_resetn,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [31:0]     req_addr,
  output logic [NREG-1:0] tgt_req_valid,
  input  logic [NREG-1:0] tgt_req_ready,
  input  logic [NREG-1:0] tgt_rsp_fire,
  output logic            err_rsp_valid,
  input  logic            err_rsp_ready,
  output logic [15:0]     err_count,
  output logic [31:0]     err_addr
);

  localparam int            CW      = out_cnt_width(MAX_OUT);
  localparam int            IW      = (NREG > 1) ? $clog2(NREG) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUT);

  router_state_t   state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [IW-1:0]   cur_tgt_q, cur_tgt_d;
  logic [IW-1:0]   sel_idx;
  logic [NREG-1:0] sel;
  logic            no_match;

  ic_region_match #(
    .NREG      (NREG),
    .MAP_MATCH (MAP_MATCH),
    .MAP_MASK  (MAP_MASK)
  ) u_region_match (
    .addr     (req_addr),
    .sel      (sel),
    .no_match (no_match)
  );

  // Binary index of the one-hot region select.
  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < NREG; i++) begin
      if (sel[i]) sel_idx = IW'(i);
    end
  end

  // Next state, forwarding, handshakes and outstanding-count bookkeeping.
  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    cur_tgt_d     = cur_tgt_q;
    tgt_req_valid = '0;
    req_ready     = 1'b0;
    err_rsp_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (no_match) begin
          // Unmapped: swallow the request and answer with an error next cycle.
          req_ready = req_valid;
          if (req_valid) state_d = ST_ERR;
        end else begin
          tgt_req_valid = sel & {NREG{req_valid}};
          req_ready     = req_valid & (|(sel & tgt_req_ready));
          if (req_ready) begin
            state_d   = ST_ROUTE;
            count_d   = CW'(1);
            cur_tgt_d = sel_idx;
          end
        end
      end
      ST_ROUTE: begin
        // Only more traffic to the same target may overlap; anything else
        // (other target or unmapped) waits until the target drains.
        if (!no_match && (sel_idx == cur_tgt_q) && (count_q < CNT_MAX)) begin
          tgt_req_valid = sel & {NREG{req_valid}};
          req_ready     = req_valid & tgt_req_ready[cur_tgt_q];
        end
        // count_q >= 1 here, so a response can never underflow it.
        count_d = count_q + CW'(req_ready) - CW'(tgt_rsp_fire[cur_tgt_q]);
        if (count_d == '0) state_d = ST_IDLE;
      end
      ST_ERR: begin
        err_rsp_valid = 1'b1;
        if (err_rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Router state registers with synchronous reset.
  // NOTE: sequential state uses <= so every register samples pre-edge values,
  // independent of the order the simulator evaluates blocks.
  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      cur_tgt_q <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      cur_tgt_q <= cur_tgt_d;
    end
  end

`ifdef IC_ADDR_ROUTER_ERRLOG_EN
  logic [15:0] err_count_q;
  logic [31:0] err_addr_q;
  logic        err_accept;

  assign err_accept = (state_q == ST_IDLE) & req_valid & no_match;

  // Log each accepted decode error: saturating count and failing address.
  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      err_count_q <= '0;
      err_addr_q  <= '0;
    end else if (err_accept) begin
      if (err_count_q != 16'hFFFF) err_count_q <= err_count_q + 16'd1;
      err_addr_q <= req_addr;
    end
  end

  assign err_count = err_count_q;
  assign err_addr  = err_addr_q;
`else
  assign err_count = '0;
  assign err_addr  = '0;
`endif

endmodule

// File: tb/tb_ic_addr_router.sv
// Self-checking bench for ic_addr_router (default 3-region map, MAX_OUT=4).
// A transaction-level model tracks outstanding count, current target and a
// pending error, and predicts the outputs each cycle; directed scenarios also
// check hand-derived constants.
module tb_ic_addr_router;

  localparam int NREG    = 3;
  localparam int MAX_OUT = 4;

  logic        g_clk = 1'b0;
  logic        g_resetn;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [2:0]  tgt_req_valid;
  logic [2:0]  tgt_req_ready;
  logic [2:0]  tgt_rsp_fire;
  logic        err_rsp_valid;
  logic        err_rsp_ready;
  logic [15:0] err_count;
  logic [31:0] err_addr;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 g_clk = ~g_clk;

  ic_addr_router #(.NREG(NREG), .MAX_OUT(MAX_OUT)) dut (
    .g_clk         (g_clk),
    .g_resetn      (g_resetn),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_addr      (req_addr),
    .tgt_req_valid (tgt_req_valid),
    .tgt_req_ready (tgt_req_ready),
    .tgt_rsp_fire  (tgt_rsp_fire),
    .err_rsp_valid (err_rsp_valid),
    .err_rsp_ready (err_rsp_ready),
    .err_count     (err_count),
    .err_addr      (err_addr)
  );

  // ---------------- reference model ----------------
  logic [31:0] r_base [NREG] = '{32'h1000_0000, 32'h2000_0000, 32'h4000_0000};
  logic [31:0] r_mask [NREG] = '{32'hFFFF_C000, 32'hFFFF_0000, 32'hF000_0000};

  int          m_cnt    = 0;
  int          m_tgt    = 0;
  bit          m_err    = 1'b0;
  logic [15:0] m_ecount = '0;
  logic [31:0] m_eaddr  = '0;

  function automatic int region_of(input logic [31:0] a);
    for (int i = 0; i < NREG; i++)
      if ((a & r_mask[i]) == r_base[i]) return i;
    return -1;
  endfunction

  // Expected {req_ready, tgt_req_valid, err_rsp_valid, err_count, err_addr}.
  function automatic logic [52:0] expv();
    logic       rr;
    logic [2:0] tv;
    int         r;
    rr = 1'b0;
    tv = 3'b000;
    r  = region_of(req_addr);
    if (!m_err) begin
      if (r < 0) begin
        rr = (m_cnt == 0) && req_valid;
      end else if (m_cnt == 0 || (r == m_tgt && m_cnt < MAX_OUT)) begin
        tv = req_valid ? 3'(1 << r) : 3'b000;
        rr = req_valid && tgt_req_ready[r];
      end
    end
    return {rr, tv, m_err, m_ecount, m_eaddr};
  endfunction

  function automatic logic [52:0] obsv();
    return {req_ready, tgt_req_valid, err_rsp_valid, err_count, err_addr};
  endfunction

  // Apply one cycle of inputs at the falling edge; outputs settle 1 ns later.
  task automatic drive(input logic rstn, input logic rv, input logic [31:0] a,
                       input logic [2:0] trdy, input logic [2:0] rsp,
                       input logic erdy);
    @(negedge g_clk);
    g_resetn      = rstn;
    req_valid     = rv;
    req_addr      = a;
    tgt_req_ready = trdy;
    tgt_rsp_fire  = rsp;
    err_rsp_ready = erdy;
    #1;
  endtask

  // Advance the clock and move the model by one cycle.
  task automatic tick();
    logic [52:0] e;
    int          r;
    e = expv();
    r = region_of(req_addr);
    @(posedge g_clk);
    if (!g_resetn) begin
      m_cnt = 0; m_tgt = 0; m_err = 1'b0; m_ecount = '0; m_eaddr = '0;
    end else if (m_err) begin
      if (err_rsp_ready) m_err = 1'b0;
    end else if (m_cnt == 0) begin
      if (req_valid && r < 0) begin
        m_err = 1'b1;
`ifdef IC_ADDR_ROUTER_ERRLOG_EN
        if (m_ecount != 16'hFFFF) m_ecount = m_ecount + 16'd1;
        m_eaddr = req_addr;
`endif
      end else if (e[52]) begin
        m_cnt = 1;
        m_tgt = r;
      end
    end else begin
      m_cnt = m_cnt + int'(e[52]) - int'(tgt_rsp_fire[m_tgt]);
    end
  endtask

  // Retire everything outstanding (stimulus only, bounded).
  task automatic drain();
    for (int g = 0; g < 40 && (m_cnt > 0 || m_err); g++) begin
      drive(1'b1, 1'b0, 32'h0, 3'b000, (m_cnt > 0) ? 3'(1 << m_tgt) : 3'b000, 1'b1);
      tick();
    end
  endtask

  typedef struct packed {
    logic        rstn;
    logic        rv;
    logic [31:0] a;
    logic [2:0]  trdy;
    logic [2:0]  rsp;
    logic        erdy;
    logic        rr;
    logic [2:0]  tv;
    logic        err;
  } step_t;

  // ---------------- scenarios ----------------
  task automatic test_reset();
    drive(1'b0, 1'b0, 32'h0, 3'b000, 3'b000, 1'b0);
    tick();
    drive(1'b0, 1'b1, 32'h1000_0000, 3'b111, 3'b111, 1'b0);
    tick();
    drive(1'b1, 1'b0, 32'h0, 3'b000, 3'b000, 1'b0);
    n_tests++;
    if (obsv() !== 53'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h want 0", obsv());
    end
    n_tests++;
    if (obsv() !== expv()) begin
      n_fail++;
      $display("FAIL reset_model: got %h want %h", obsv(), expv());
    end
    tick();
  endtask

  task automatic test_route_basic();
    step_t st[5];
    st = '{
      '{1'b1, 1'b1, 32'h1000_0010, 3'b001, 3'b000, 1'b0, 1'b1, 3'b001, 1'b0},
      '{1'b1, 1'b1, 32'h2000_0000, 3'b010, 3'b000, 1'b0, 1'b0, 3'b000, 1'b0},
      '{1'b1, 1'b1, 32'h1000_0020, 3'b000, 3'b000, 1'b0, 1'b0, 3'b001, 1'b0},
      '{1'b1, 1'b0, 32'h0000_0000, 3'b000, 3'b001, 1'b0, 1'b0, 3'b000, 1'b0},
      '{1'b1, 1'b1, 32'h2000_0000, 3'b000, 3'b000, 1'b0, 1'b0, 3'b010, 1'b0}};
    for (int k = 0; k < 5; k++) begin
      drive(st[k].rstn, st[k].rv, st[k].a, st[k].trdy, st[k].rsp, st[k].erdy);
      n_tests++;
      if ({req_ready, tgt_req_valid, err_rsp_valid} !== {st[k].rr, st[k].tv, st[k].err}) begin
        n_fail++;
        $display("FAIL route_basic[%0d]: got rr=%b tv=%b err=%b want rr=%b tv=%b err=%b",
                 k, req_ready, tgt_req_valid, err_rsp_valid, st[k].rr, st[k].tv, st[k].err);
      end
      n_tests++;
      if (obsv() !== expv()) begin
        n_fail++;
        $display("FAIL route_basic_model[%0d]: got %h want %h", k, obsv(), expv());
      end
      tick();
    end
    drain();
  endtask

  task automatic test_max_out();
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, 1'b1, 32'h2000_0000 + 32'(k * 4), 3'b010,
            (k == 4) ? 3'b010 : 3'b000, 1'b0);
      n_tests++;
      if ({req_ready, tgt_req_valid} !== ((k == 4) ? 4'b0_000 : 4'b1_010)) begin
        n_fail++;
        $display("FAIL max_out[%0d]: got rr=%b tv=%b", k, req_ready, tgt_req_valid);
      end
      n_tests++;
      if (obsv() !== expv()) begin
        n_fail++;
        $display("FAIL max_out_model[%0d]: got %h want %h", k, obsv(), expv());
      end
      tick();
    end
    drain();
  endtask

  task automatic test_stall_other();
    step_t st[4];
    st = '{
      '{1'b1, 1'b1, 32'h1000_0000, 3'b001, 3'b000, 1'b0, 1'b1, 3'b001, 1'b0},
      '{1'b1, 1'b1, 32'h4000_0000, 3'b100, 3'b000, 1'b0, 1'b0, 3'b000, 1'b0},
      '{1'b1, 1'b1, 32'h4000_0000, 3'b100, 3'b001, 1'b0, 1'b0, 3'b000, 1'b0},
      '{1'b1, 1'b1, 32'h4000_0000, 3'b100, 3'b000, 1'b0, 1'b1, 3'b100, 1'b0}};
    for (int k = 0; k < 4; k++) begin
      drive(st[k].rstn, st[k].rv, st[k].a, st[k].trdy, st[k].rsp, st[k].erdy);
      n_tests++;
      if ({req_ready, tgt_req_valid, err_rsp_valid} !== {st[k].rr, st[k].tv, st[k].err}) begin
        n_fail++;
        $display("FAIL stall_other[%0d]: got rr=%b tv=%b err=%b want rr=%b tv=%b err=%b",
                 k, req_ready, tgt_req_valid, err_rsp_valid, st[k].rr, st[k].tv, st[k].err);
      end
      n_tests++;
      if (obsv() !== expv()) begin
        n_fail++;
        $display("FAIL stall_other_model[%0d]: got %h want %h", k, obsv(), expv());
      end
      tick();
    end
    drain();
  endtask

  task automatic test_decode_err();
    step_t       st[8];
    logic [15:0] exp_cnt1, exp_cnt2;
    logic [31:0] exp_addr1, exp_addr2;
`ifdef IC_ADDR_ROUTER_ERRLOG_EN
    exp_cnt1 = 16'd1; exp_addr1 = 32'h3000_0000;
    exp_cnt2 = 16'd2; exp_addr2 = 32'h1000_4000;
`else
    exp_cnt1 = 16'd0; exp_addr1 = 32'h0;
    exp_cnt2 = 16'd0; exp_addr2 = 32'h0;
`endif
    st = '{
      '{1'b1, 1'b1, 32'h3000_0000, 3'b111, 3'b000, 1'b0, 1'b1, 3'b000, 1'b0},
      '{1'b1, 1'b1, 32'h1000_0000, 3'b111, 3'b000, 1'b0, 1'b0, 3'b000, 1'b1},
      '{1'b1, 1'b1, 32'h1000_0000, 3'b111, 3'b000, 1'b0, 1'b0, 3'b000, 1'b1},
      '{1'b1, 1'b1, 32'h1000_0000, 3'b111, 3'b000, 1'b0, 1'b0, 3'b000, 1'b1},
      '{1'b1, 1'b0, 32'h0000_0000, 3'b000, 3'b000, 1'b1, 1'b0, 3'b000, 1'b1},
      '{1'b1, 1'b1, 32'h1000_4000, 3'b001, 3'b000, 1'b0, 1'b1, 3'b000, 1'b0},
      '{1'b1, 1'b0, 32'h0000_0000, 3'b000, 3'b000, 1'b1, 1'b0, 3'b000, 1'b1},
      '{1'b1, 1'b0, 32'h0000_0000, 3'b000, 3'b000, 1'b0, 1'b0, 3'b000, 1'b0}};
    for (int k = 0; k < 8; k++) begin
      drive(st[k].rstn, st[k].rv, st[k].a, st[k].trdy, st[k].rsp, st[k].erdy);
      n_tests++;
      if ({req_ready, tgt_req_valid, err_rsp_valid} !== {st[k].rr, st[k].tv, st[k].err}) begin
        n_fail++;
        $display("FAIL decode_err[%0d]: got rr=%b tv=%b err=%b want rr=%b tv=%b err=%b",
                 k, req_ready, tgt_req_valid, err_rsp_valid, st[k].rr, st[k].tv, st[k].err);
      end
      n_tests++;
      if (obsv() !== expv()) begin
        n_fail++;
        $display("FAIL decode_err_model[%0d]: got %h want %h", k, obsv(), expv());
      end
      if (k == 4) begin
        n_tests++;
        if ({err_count, err_addr} !== {exp_cnt1, exp_addr1}) begin
          n_fail++;
          $display("FAIL err_log_first: got cnt=%0d addr=%h want cnt=%0d addr=%h",
                   err_count, err_addr, exp_cnt1, exp_addr1);
        end
      end
      if (k == 7) begin
        n_tests++;
        if ({err_count, err_addr} !== {exp_cnt2, exp_addr2}) begin
          n_fail++;
          $display("FAIL err_log_second: got cnt=%0d addr=%h want cnt=%0d addr=%h",
                   err_count, err_addr, exp_cnt2, exp_addr2);
        end
      end
      tick();
    end
  endtask

  task automatic test_simul_fire();
    step_t st[7];
    st = '{
      '{1'b1, 1'b1, 32'h2000_0000, 3'b010, 3'b000, 1'b0, 1'b1, 3'b010, 1'b0},
      '{1'b1, 1'b1, 32'h2000_0004, 3'b010, 3'b000, 1'b0, 1'b1, 3'b010, 1'b0},
      '{1'b1, 1'b1, 32'h2000_0008, 3'b010, 3'b010, 1'b0, 1'b1, 3'b010, 1'b0},
      '{1'b1, 1'b0, 32'h0000_0000, 3'b000, 3'b010, 1'b0, 1'b0, 3'b000, 1'b0},
      '{1'b1, 1'b1, 32'h1000_0000, 3'b001, 3'b000, 1'b0, 1'b0, 3'b000, 1'b0},
      '{1'b1, 1'b0, 32'h0000_0000, 3'b000, 3'b010, 1'b0, 1'b0, 3'b000, 1'b0},
      '{1'b1, 1'b1, 32'h1000_0000, 3'b000, 3'b000, 1'b0, 1'b0, 3'b001, 1'b0}};
    for (int k = 0; k < 7; k++) begin
      drive(st[k].rstn, st[k].rv, st[k].a, st[k].trdy, st[k].rsp, st[k].erdy);
      n_tests++;
      if ({req_ready, tgt_req_valid, err_rsp_valid} !== {st[k].rr, st[k].tv, st[k].err}) begin
        n_fail++;
        $display("FAIL simul_fire[%0d]: got rr=%b tv=%b err=%b want rr=%b tv=%b err=%b",
                 k, req_ready, tgt_req_valid, err_rsp_valid, st[k].rr, st[k].tv, st[k].err);
      end
      n_tests++;
      if (obsv() !== expv()) begin
        n_fail++;
        $display("FAIL simul_fire_model[%0d]: got %h want %h", k, obsv(), expv());
      end
      tick();
    end
    drain();
  endtask

  task automatic test_reset_mid();
    step_t st[8];
    st = '{
      '{1'b1, 1'b1, 32'h1000_0000, 3'b001, 3'b000, 1'b0, 1'b1, 3'b001, 1'b0},
      '{1'b0, 1'b1, 32'h1000_0000, 3'b001, 3'b001, 1'b0, 1'b1, 3'b001, 1'b0},
      '{1'b1, 1'b0, 32'h0000_0000, 3'b000, 3'b000, 1'b0, 1'b0, 3'b000, 1'b0},
      '{1'b1, 1'b1, 32'h4000_0000, 3'b100, 3'b000, 1'b0, 1'b1, 3'b100, 1'b0},
      '{1'b1, 1'b0, 32'h0000_0000, 3'b000, 3'b100, 1'b0, 1'b0, 3'b000, 1'b0},
      '{1'b1, 1'b1, 32'h3000_0000, 3'b000, 3'b000, 1'b0, 1'b1, 3'b000, 1'b0},
      '{1'b0, 1'b0, 32'h0000_0000, 3'b000, 3'b000, 1'b0, 1'b0, 3'b000, 1'b1},
      '{1'b1, 1'b0, 32'h0000_0000, 3'b000, 3'b000, 1'b0, 1'b0, 3'b000, 1'b0}};
    for (int k = 0; k < 8; k++) begin
      drive(st[k].rstn, st[k].rv, st[k].a, st[k].trdy, st[k].rsp, st[k].erdy);
      n_tests++;
      if ({req_ready, tgt_req_valid, err_rsp_valid} !== {st[k].rr, st[k].tv, st[k].err}) begin
        n_fail++;
        $display("FAIL reset_mid[%0d]: got rr=%b tv=%b err=%b want rr=%b tv=%b err=%b",
                 k, req_ready, tgt_req_valid, err_rsp_valid, st[k].rr, st[k].tv, st[k].err);
      end
      if (k == 2 || k == 7) begin
        n_tests++;
        if ({err_count, err_addr} !== 48'd0) begin
          n_fail++;
          $display("FAIL reset_mid_log[%0d]: got cnt=%0d addr=%h want 0", k, err_count, err_addr);
        end
      end
      n_tests++;
      if (obsv() !== expv()) begin
        n_fail++;
        $display("FAIL reset_mid_model[%0d]: got %h want %h", k, obsv(), expv());
      end
      tick();
    end
  endtask

  task automatic test_random();
    logic [31:0] pick [8] = '{32'h1000_0000, 32'h1000_3FFC, 32'h1000_4000,
                              32'h2000_0100, 32'h2001_0000, 32'h4ABC_0000,
                              32'h3000_0000, 32'h0000_0000};
    logic        rstn;
    logic [31:0] a;
    for (int k = 0; k < 800; k++) begin
      rstn = ($urandom_range(0, 63) != 0);
      a    = ($urandom_range(0, 3) == 0) ? $urandom() : pick[$urandom_range(0, 7)];
      drive(rstn, 1'($urandom_range(0, 3) != 0), a, 3'($urandom()),
            ($urandom_range(0, 2) == 0) ? 3'($urandom()) : 3'b000,
            1'($urandom_range(0, 1)));
      n_tests++;
      if (obsv() !== expv()) begin
        n_fail++;
        $display("FAIL random[%0d]: addr=%h got %h want %h", k, a, obsv(), expv());
      end
      tick();
    end
    drain();
  endtask

  initial begin
    g_resetn      = 1'b0;
    req_valid     = 1'b0;
    req_addr      = '0;
    tgt_req_ready = '0;
    tgt_rsp_fire  = '0;
    err_rsp_ready = 1'b0;
    test_reset();
    test_decode_err();
    test_route_basic();
    test_max_out();
    test_stall_other();
    test_simul_fire();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
